// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses over a valid/ready data-memory port.
// Define MISALIGNED_SPLIT_EN to perform misaligned accesses (two word accesses when crossing a word).
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            fault,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, REQ0, RESP0, REQ1, RESP1, DONE} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  offset;
    logic [7:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [63:0] store_image;
    logic        bad_req;
    logic        split_step;
    logic        load_final;
    logic [63:0] load_pair;

    logic [1:0]  offset_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [3:0]  hi_be_reg;
    logic [31:0] hi_wdata_reg;
    logic [31:0] lo_reg;

    function automatic logic [31:0] load_extend(input logic [63:0] pair, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (size)
            2'b00:   return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign stall = req_valid & ~done & ~rst;

    always_comb begin
        offset = req_addr[1:0];
        case (req_size)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            default: size_mask = 8'h0F;
        endcase
        lane_mask   = size_mask << offset;
        store_image = {32'b0, req_wdata} << {offset, 3'b000};
`ifdef MISALIGNED_SPLIT_EN
        bad_req = (req_size == 2'b11);
`else
        bad_req = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        split_step = 1'b0;
        load_final = 1'b0;
        load_pair  = {32'b0, mem_rdata};
        case (state_reg)
            IDLE:  if (req_valid) state_next = bad_req ? DONE : REQ0;
            REQ0:  if (mem_ready) begin
                       if (!mem_we)               state_next = RESP0;
                       else if (hi_be_reg != 4'b0) begin
                           state_next = REQ1;
                           split_step = 1'b1;
                       end else                   state_next = DONE;
                   end
            RESP0: if (mem_rvalid) begin
                       if (hi_be_reg != 4'b0) begin
                           state_next = REQ1;
                           split_step = 1'b1;
                       end else begin
                           state_next = DONE;
                           load_final = 1'b1;
                       end
                   end
            REQ1:  if (mem_ready) state_next = mem_we ? DONE : RESP1;
            RESP1: if (mem_rvalid) begin
                       state_next = DONE;
                       load_final = 1'b1;
                       load_pair  = {mem_rdata, lo_reg};
                   end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request parameters are latched in IDLE so the datapath never depends on the core holding req_* steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done         <= 1'b0;
            fault        <= 1'b0;
            rdata        <= '0;
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= 4'b0;
            mem_wdata    <= '0;
            offset_reg   <= 2'b0;
            size_reg     <= 2'b0;
            unsigned_reg <= 1'b0;
            hi_be_reg    <= 4'b0;
            hi_wdata_reg <= 32'b0;
            lo_reg       <= 32'b0;
        end else begin
            done      <= (state_next == DONE);
            fault     <= (state_reg == IDLE) && req_valid && bad_req;
            mem_valid <= (state_next == REQ0) || (state_next == REQ1);
            if (state_reg == IDLE && req_valid && !bad_req) begin
                mem_addr     <= {req_addr[XLEN-1:2], 2'b00};
                mem_be       <= lane_mask[3:0];
                mem_wdata    <= store_image[31:0];
                mem_we       <= req_we;
                offset_reg   <= offset;
                size_reg     <= req_size;
                unsigned_reg <= req_unsigned;
                hi_be_reg    <= lane_mask[7:4];
                hi_wdata_reg <= store_image[63:32];
            end
            if (state_reg == RESP0 && mem_rvalid)
                lo_reg <= mem_rdata;
            if (split_step) begin
                mem_addr  <= mem_addr + XLEN'(4);
                mem_be    <= hi_be_reg;
                mem_wdata <= hi_wdata_reg;
            end
            if (load_final)
                rdata <= load_extend(load_pair, offset_reg, size_reg, unsigned_reg);
        end
    end

endmodule
